// File: rtl/lsu_pkg.sv
// Shared types and address-map constants for the multi-cycle load/store unit.
package lsu_pkg;

   // Access size encoding; 2'd3 is not listed and is treated as illegal
   typedef enum logic [1:0] {
      LSU_BYTE = 2'd0,
      LSU_HALF = 2'd1,
      LSU_WORD = 2'd2
   } lsu_size_e;

   // IO region bases, compared against addr[31:12]
   localparam logic [19:0] ADDR_LEDR  = 20'h10000;
   localparam logic [19:0] ADDR_LEDG  = 20'h10001;
   localparam logic [19:0] ADDR_HEXLO = 20'h10002;
   localparam logic [19:0] ADDR_HEXHI = 20'h10003;
   localparam logic [19:0] ADDR_LCD   = 20'h10004;
   localparam logic [19:0] ADDR_SW    = 20'h10010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   // Decoded IO target for the captured address
   typedef enum logic [2:0] {
      REG_LEDR, REG_LEDG, REG_HEXLO, REG_HEXHI, REG_LCD, REG_SW, REG_NONE
   } lsu_io_e;

   // Right-aligned byte mask for an access size; illegal size writes nothing
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         LSU_BYTE: size_mask = 4'b0001;
         LSU_HALF: size_mask = 4'b0011;
         LSU_WORD: size_mask = 4'b1111;
         default:  size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Synchronous-read data memory with per-byte write enables. Contents are
// deliberately not reset.
module lsu_dmem #(
   parameter int WORDS = 2048,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_addr,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [0:WORDS-1];
   logic [31:0] r_rdata;

   // Byte-masked write and registered read (read returns pre-write data)
   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: valid/ready request, one-cycle response pulse,
// owns DMEM and the memory-mapped IO registers, splits word-crossing accesses.
module lsu_mc
   import lsu_pkg::*;
#(
   parameter int DMEM_WORDS  = 2048,
   parameter int NUM_HEX     = 8,
   parameter int MISALIGN_EN = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_st_data,
   input  logic [1:0]  i_lsu_size,
   input  logic        i_lsu_signed,
   input  logic        i_lsu_wren,
   output logic        o_rsp_valid,
   output logic [31:0] o_ld_data,
   output logic        o_lsu_err,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [6:0]  o_io_hex [0:NUM_HEX-1],
   output logic [31:0] o_io_lcd,
   input  logic [31:0] i_io_sw
);

   localparam int AW = $clog2(DMEM_WORDS);

   lsu_state_e  r_state, w_next;
   logic [31:0] r_addr, r_st_data, r_lo;
   logic [1:0]  r_size;
   logic        r_signed, r_wren;
   logic        r_rsp_valid, r_err;
   logic [31:0] r_ld_data;
   logic [31:0] r_ledr, r_ledg, r_hexlo, r_hexhi, r_lcd;

   logic          w_accept;
   logic [1:0]    w_off;
   logic [4:0]    w_sh;
   logic [29:0]   w_wa0, w_wa1;
   logic          w_in_dmem0, w_in_dmem1;
   lsu_io_e       w_io_sel;
   logic          w_is_io, w_illegal, w_misal, w_cross, w_err;
   logic [63:0]   w_st64;
   logic [7:0]    w_be8;
   logic [3:0]    w_dm_be;
   logic [AW-1:0] w_dm_addr;
   logic [31:0]   w_dm_rdata, w_io_rd, w_lo, w_ld_word, w_ld_ext;
   logic          w_io_we;
   logic [63:0]   w_hex_all;

   assign o_req_ready = (r_state == IDLE) && !i_reset;
   assign w_accept    = i_req_valid && o_req_ready;

   // ---------------- decode of the captured request ----------------
   assign w_off      = r_addr[1:0];
   assign w_sh       = {w_off, 3'b000};
   assign w_wa0      = r_addr[31:2];
   assign w_wa1      = w_wa0 + 30'd1;
   assign w_in_dmem0 = (r_addr[31:AW+2] == '0);
   assign w_in_dmem1 = (w_wa1[29:AW] == '0);

   // IO region select from the 4 KiB page number
   always_comb begin
      w_io_sel = REG_NONE;
      case (r_addr[31:12])
         ADDR_LEDR:  w_io_sel = REG_LEDR;
         ADDR_LEDG:  w_io_sel = REG_LEDG;
         ADDR_HEXLO: w_io_sel = REG_HEXLO;
         ADDR_HEXHI: w_io_sel = REG_HEXHI;
         ADDR_LCD:   w_io_sel = REG_LCD;
         ADDR_SW:    w_io_sel = REG_SW;
         default:    w_io_sel = REG_NONE;
      endcase
   end

   assign w_is_io   = (w_io_sel != REG_NONE);
   assign w_illegal = (r_size == 2'd3);
   assign w_misal   = ((r_size == LSU_HALF) && w_off[0]) ||
                      ((r_size == LSU_WORD) && (w_off != 2'd0));
   assign w_cross   = ((r_size == LSU_HALF) && (w_off == 2'd3)) ||
                      ((r_size == LSU_WORD) && (w_off != 2'd0));
   // A crossing access is only legal when both words sit inside DMEM
   assign w_err     = w_illegal ||
                      (!w_in_dmem0 && !w_is_io) ||
                      (w_misal && (MISALIGN_EN == 0)) ||
                      (w_cross && !(w_in_dmem0 && w_in_dmem1));

   // Lane steering across a two-word window: low word goes in ACC0, high in ACC1
   assign w_st64 = {32'd0, r_st_data} << w_sh;
   assign w_be8  = {4'd0, size_mask(r_size)} << w_off;

   // ---------------- FSM ----------------
   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // Next-state: errored requests never visit ACC1
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = ACC0;
         ACC0:    w_next = (w_cross && !w_err) ? ACC1 : RESP;
         ACC1:    w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Capture all request fields on acceptance
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr    <= '0;
         r_st_data <= '0;
         r_size    <= '0;
         r_signed  <= 1'b0;
         r_wren    <= 1'b0;
      end else if (w_accept) begin
         r_addr    <= i_lsu_addr;
         r_st_data <= i_st_data;
         r_size    <= i_lsu_size;
         r_signed  <= i_lsu_signed;
         r_wren    <= i_lsu_wren;
      end
   end

   // ---------------- DMEM ----------------
   assign w_dm_addr = (r_state == ACC1) ? w_wa1[AW-1:0] : w_wa0[AW-1:0];

   // Byte enables for the word issued in the current access cycle
   always_comb begin
      w_dm_be = 4'b0000;
      if (r_wren && !w_err && w_in_dmem0) begin
         if (r_state == ACC0)      w_dm_be = w_be8[3:0];
         else if (r_state == ACC1) w_dm_be = w_be8[7:4];
      end
   end

   lsu_dmem #(.WORDS(DMEM_WORDS), .AW(AW)) u_dmem (
      .i_clk   (i_clk),
      .i_addr  (w_dm_addr),
      .i_be    (w_dm_be),
      .i_wdata ((r_state == ACC1) ? w_st64[63:32] : w_st64[31:0]),
      .o_rdata (w_dm_rdata)
   );

   // ---------------- IO registers ----------------
   // IO read mux; SW is live and gets sampled during ACC0
   always_comb begin
      w_io_rd = 32'd0;
      case (w_io_sel)
         REG_LEDR:  w_io_rd = r_ledr;
         REG_LEDG:  w_io_rd = r_ledg;
         REG_HEXLO: w_io_rd = r_hexlo;
         REG_HEXHI: w_io_rd = r_hexhi;
         REG_LCD:   w_io_rd = r_lcd;
         REG_SW:    w_io_rd = i_io_sw;
         default:   w_io_rd = 32'd0;
      endcase
   end

   // IO accesses never cross, so only ACC0 writes; SW stores fall through silently
   assign w_io_we = (r_state == ACC0) && r_wren && !w_err && w_is_io;

   // Byte-enabled IO register writes
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ledr  <= '0;
         r_ledg  <= '0;
         r_hexlo <= '0;
         r_hexhi <= '0;
         r_lcd   <= '0;
      end else if (w_io_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be8[b]) begin
               case (w_io_sel)
                  REG_LEDR:  r_ledr[8*b +: 8]  <= w_st64[8*b +: 8];
                  REG_LEDG:  r_ledg[8*b +: 8]  <= w_st64[8*b +: 8];
                  REG_HEXLO: r_hexlo[8*b +: 8] <= w_st64[8*b +: 8];
                  REG_HEXHI: r_hexhi[8*b +: 8] <= w_st64[8*b +: 8];
                  REG_LCD:   r_lcd[8*b +: 8]   <= w_st64[8*b +: 8];
                  default:   ;
               endcase
            end
         end
      end
   end

   // ---------------- load assembly ----------------
   // Low word: IO sample from ACC0, or DMEM word 0 saved while word 1 is read
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                r_lo <= '0;
      else if (r_state == ACC0)   r_lo <= w_io_rd;
      else if (r_state == ACC1)   r_lo <= w_dm_rdata;
   end

   assign w_lo      = (w_in_dmem0 && !w_cross) ? w_dm_rdata : r_lo;
   assign w_ld_word = 32'({w_dm_rdata, w_lo} >> w_sh);

   // Sign/zero extension by access size
   always_comb begin
      w_ld_ext = w_ld_word;
      case (r_size)
         LSU_BYTE: w_ld_ext = {{24{r_signed & w_ld_word[7]}},  w_ld_word[7:0]};
         LSU_HALF: w_ld_ext = {{16{r_signed & w_ld_word[15]}}, w_ld_word[15:0]};
         default:  w_ld_ext = w_ld_word;
      endcase
   end

   // Registered response: pulse leaves RESP together with data and error
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rsp_valid <= 1'b0;
         r_ld_data   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_rsp_valid <= (r_state == RESP);
         r_ld_data   <= ((r_state == RESP) && !r_wren && !w_err) ? w_ld_ext : 32'd0;
         r_err       <= (r_state == RESP) && w_err;
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_ld_data   = r_ld_data;
   assign o_lsu_err   = r_err;
   assign o_io_ledr   = r_ledr;
   assign o_io_ledg   = r_ledg;
   assign o_io_lcd    = r_lcd;

   // Digit i shows the low 7 bits of byte i of {HEXHI, HEXLO}
   assign w_hex_all = {r_hexhi, r_hexlo};
   for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
      assign o_io_hex[g] = w_hex_all[8*g +: 7];
   end

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: directed vector table, byte-level reference model under
// random traffic, reset-in-split-store and MISALIGN_EN=0 sequences.
module tb_lsu_mc;

   localparam int DW0 = 2048;

   logic        clk = 1'b0, rst = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [31:0] addr = '0, std = '0, sw = '0;
   logic [1:0]  size = '0;
   logic        sgn = 1'b0, wren = 1'b0;

   logic        rdy0, rsp0, err0, rdy1, rsp1, err1;
   logic [31:0] ld0, ledr0, ledg0, lcd0, ld1, ledr1, ledg1, lcd1;
   logic [6:0]  hex0 [0:7];
   logic [6:0]  hex1 [0:3];

   int checks = 0, errors = 0;

   // Byte-level reference state: DMEM bytes and IO regs LEDR,LEDG,HEXLO,HEXHI,LCD
   logic [7:0]  mm  [0:DW0*4-1];
   logic [31:0] mio [0:4];

   always #5 clk = ~clk;

   lsu_mc #(.DMEM_WORDS(DW0), .NUM_HEX(8), .MISALIGN_EN(1)) u0 (
      .i_clk(clk), .i_reset(rst), .i_req_valid(v0), .o_req_ready(rdy0),
      .i_lsu_addr(addr), .i_st_data(std), .i_lsu_size(size), .i_lsu_signed(sgn),
      .i_lsu_wren(wren), .o_rsp_valid(rsp0), .o_ld_data(ld0), .o_lsu_err(err0),
      .o_io_ledr(ledr0), .o_io_ledg(ledg0), .o_io_hex(hex0), .o_io_lcd(lcd0),
      .i_io_sw(sw));

   lsu_mc #(.DMEM_WORDS(256), .NUM_HEX(4), .MISALIGN_EN(0)) u1 (
      .i_clk(clk), .i_reset(rst), .i_req_valid(v1), .o_req_ready(rdy1),
      .i_lsu_addr(addr), .i_st_data(std), .i_lsu_size(size), .i_lsu_signed(sgn),
      .i_lsu_wren(wren), .o_rsp_valid(rsp1), .o_ld_data(ld1), .o_lsu_err(err1),
      .o_io_ledr(ledr1), .o_io_ledg(ledg1), .o_io_hex(hex1), .o_io_lcd(lcd1),
      .i_io_sw(sw));

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   // One request to DUT d; lat = edges from acceptance to the sampled pulse (-1 = none)
   task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] dt,
                         input logic [1:0] sz, input logic sg, input logic wr,
                         output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      addr = a; std = dt; size = sz; sgn = sg; wren = wr;
      if (d == 0) v0 = 1'b1; else v1 = 1'b1;
      n = 0;
      while (!((d == 0) ? rdy0 : rdy1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", d, 32'd0, 32'd1);
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      lat = -1; rd = 'x; er = 1'bx;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if ((d == 0) ? rsp0 : rsp1) begin
            lat = i;
            rd  = (d == 0) ? ld0 : ld1;
            er  = (d == 0) ? err0 : err1;
            break;
         end
      end
   endtask

   // Reference: applies the access byte by byte from the address-map rules
   task automatic model_req(input logic [31:0] a, input logic [31:0] dt, input logic [1:0] sz,
                            input logic sg, input logic wr,
                            output logic [31:0] rd, output logic er, output int lat);
      int n, ri;
      bit ill, mis, cr, dm;
      logic [7:0] b;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ill = (sz == 2'd3);
      mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      cr  = (int'(a[1:0]) + n) > 4;
      dm  = a < 32'(DW0 * 4);
      case (a[31:12])
         20'h10000: ri = 0;
         20'h10001: ri = 1;
         20'h10002: ri = 2;
         20'h10003: ri = 3;
         20'h10004: ri = 4;
         20'h10010: ri = 5;
         default:   ri = -1;
      endcase
      er = ill || !(dm || ri >= 0) || (cr && !(dm && (a + 32'(n - 1)) < 32'(DW0 * 4)));
      rd = 32'd0;
      if (!er) begin
         for (int k = 0; k < n; k++) begin
            if (wr) begin
               if (dm)          mm[a + 32'(k)] = dt[8*k +: 8];
               else if (ri < 5) mio[ri][8*((int'(a[1:0]) + k) % 4) +: 8] = dt[8*k +: 8];
            end else begin
               if (dm)           b = mm[a + 32'(k)];
               else if (ri == 5) b = sw[8*((int'(a[1:0]) + k) % 4) +: 8];
               else              b = mio[ri][8*((int'(a[1:0]) + k) % 4) +: 8];
               rd[8*k +: 8] = b;
            end
         end
         if (!wr && sg && n == 1) rd = {{24{rd[7]}}, rd[7:0]};
         if (!wr && sg && n == 2) rd = {{16{rd[15]}}, rd[15:0]};
      end
      lat = (cr && !er) ? 3 : 2;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  sz;
      logic        sg;
      logic        wr;
      logic [31:0] ed;
      logic        ee;
      int          el;
   } vec_t;

   vec_t tv [19];

   initial begin
      logic [31:0] rd, mrd, a, hx;
      logic        er, mer;
      int          lat, mlat, cat;
      logic [1:0]  sz;
      logic [7:0]  b80, b81;
      logic [63:0] hall;
      logic [19:0] iob [6];

      for (int i = 0; i < DW0 * 4; i++) mm[i] = 8'h00;
      for (int i = 0; i < 5; i++) mio[i] = 32'd0;

      // -------- reset state --------
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 0, 32'(rdy0), 32'd0);
      chk("rst_rsp",   0, 32'(rsp0), 32'd0);
      chk("rst_ld",    0, ld0, 32'd0);
      chk("rst_err",   0, 32'(err0), 32'd0);
      chk("rst_ledr",  0, ledr0, 32'd0);
      @(negedge clk) rst = 1'b0;
      #1 chk("ready_after_rst", 0, 32'(rdy0), 32'd1);

      // -------- fill the DMEM windows used below --------
      for (int w = 0; w < 32'h110; w += 4) begin
         a = $urandom;
         do_req(0, 32'(w), a, 2'd2, 1'b0, 1'b1, rd, er, lat);
         model_req(32'(w), a, 2'd2, 1'b0, 1'b1, mrd, mer, mlat);
         chk("fill_err", w, 32'(er), 32'd0);
      end
      for (int w = 32'h1FE0; w < 32'h2000; w += 4) begin
         a = $urandom;
         do_req(0, 32'(w), a, 2'd2, 1'b0, 1'b1, rd, er, lat);
         model_req(32'(w), a, 2'd2, 1'b0, 1'b1, mrd, mer, mlat);
      end

      // -------- directed vectors --------
      sw = 32'hDEAD_BEEF;
      tv[0]  = '{32'h0000_0040, 32'h8765_4321, 2'd2, 1'b0, 1'b1, 32'h0,         1'b0, 2};
      tv[1]  = '{32'h0000_0040, 32'h0,         2'd2, 1'b0, 1'b0, 32'h8765_4321, 1'b0, 2};
      tv[2]  = '{32'h0000_0043, 32'h0000_F00D, 2'd1, 1'b0, 1'b1, 32'h0,         1'b0, 3};
      tv[3]  = '{32'h0000_0043, 32'h0,         2'd0, 1'b0, 1'b0, 32'h0000_000D, 1'b0, 2};
      tv[4]  = '{32'h0000_0044, 32'h0,         2'd0, 1'b0, 1'b0, 32'h0000_00F0, 1'b0, 2};
      tv[5]  = '{32'h0000_0043, 32'h0,         2'd1, 1'b1, 1'b0, 32'hFFFF_F00D, 1'b0, 3};
      tv[6]  = '{32'h0000_0043, 32'h0,         2'd1, 1'b0, 1'b0, 32'h0000_F00D, 1'b0, 3};
      tv[7]  = '{32'h0000_0080, 32'h0000_0080, 2'd0, 1'b0, 1'b1, 32'h0,         1'b0, 2};
      tv[8]  = '{32'h0000_0080, 32'h0,         2'd0, 1'b1, 1'b0, 32'hFFFF_FF80, 1'b0, 2};
      tv[9]  = '{32'h0000_0080, 32'h0,         2'd0, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 2};
      tv[10] = '{32'h1000_2000, 32'h0000_3F06, 2'd2, 1'b0, 1'b1, 32'h0,         1'b0, 2};
      tv[11] = '{32'h1001_0000, 32'h1234_5678, 2'd2, 1'b0, 1'b1, 32'h0,         1'b0, 2};
      tv[12] = '{32'h1001_0000, 32'h0,         2'd2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2};
      tv[13] = '{32'h2000_0000, 32'h0,         2'd2, 1'b0, 1'b0, 32'h0,         1'b1, 2};
      tv[14] = '{32'h0000_0040, 32'h0,         2'd3, 1'b0, 1'b0, 32'h0,         1'b1, 2};
      tv[15] = '{32'h1000_0001, 32'h0,         2'd2, 1'b0, 1'b0, 32'h0,         1'b1, 2};
      tv[16] = '{32'h0000_1FFE, 32'h0,         2'd2, 1'b0, 1'b0, 32'h0,         1'b1, 2};
      tv[17] = '{32'h0000_0041, 32'h0,         2'd1, 1'b0, 1'b0, 32'h0000_6543, 1'b0, 2};
      tv[18] = '{32'h1000_0002, 32'h0000_00AB, 2'd0, 1'b0, 1'b1, 32'h0,         1'b0, 2};
      for (int i = 0; i < 19; i++) begin
         do_req(0, tv[i].a, tv[i].d, tv[i].sz, tv[i].sg, tv[i].wr, rd, er, lat);
         model_req(tv[i].a, tv[i].d, tv[i].sz, tv[i].sg, tv[i].wr, mrd, mer, mlat);
         chk("tv_data", i, rd, tv[i].ed);
         chk("tv_err",  i, 32'(er), 32'(tv[i].ee));
         chk("tv_lat",  i, 32'(lat), 32'(tv[i].el));
      end
      chk("hex0", 0, 32'(hex0[0]), 32'h06);
      chk("hex1", 1, 32'(hex0[1]), 32'h3F);
      for (int g = 2; g < 8; g++) chk("hex_other", g, 32'(hex0[g]), 32'h0);
      chk("ledr_byte", 0, ledr0, 32'h00AB_0000);

      // -------- random traffic vs reference --------
      iob = '{20'h10000, 20'h10001, 20'h10002, 20'h10003, 20'h10004, 20'h10010};
      for (int i = 0; i < 300; i++) begin
         cat = $urandom_range(0, 5);
         if (cat <= 2)      a = 32'($urandom_range(0, 255));
         else if (cat == 3) a = 32'h1FF0 + 32'($urandom_range(0, 15));
         else if (cat == 4) a = {iob[$urandom_range(0, 5)], 12'($urandom_range(0, 4095))};
         else               a = 32'h2000_0000 | 32'($urandom);
         sz = 2'($urandom_range(0, 3));
         sw = $urandom;
         std = $urandom;
         hx = std;
         do_req(0, a, hx, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, er, lat);
         model_req(a, hx, sz, sgn, wren, mrd, mer, mlat);
         chk("rnd_data", i, rd, mrd);
         chk("rnd_err",  i, 32'(er), 32'(mer));
         chk("rnd_lat",  i, 32'(lat), 32'(mlat));
      end
      chk("rnd_ledr", 0, ledr0, mio[0]);
      chk("rnd_ledg", 0, ledg0, mio[1]);
      chk("rnd_lcd",  0, lcd0,  mio[4]);
      hall = {mio[3], mio[2]};
      for (int g = 0; g < 8; g++) chk("rnd_hex", g, 32'(hex0[g]), 32'(hall[8*g +: 7]));

      // -------- reset during ACC1 of a split word store at 0x7E --------
      do_req(0, 32'h1000_0000, 32'h0000_0055, 2'd2, 1'b0, 1'b1, rd, er, lat);
      model_req(32'h1000_0000, 32'h0000_0055, 2'd2, 1'b0, 1'b1, mrd, mer, mlat);
      chk("pre_rst_ledr", 0, ledr0, mio[0]);
      b80 = mm[32'h80];
      b81 = mm[32'h81];
      @(negedge clk);
      addr = 32'h7E; std = 32'hA1B2_C3D4; size = 2'd2; sgn = 1'b0; wren = 1'b1; v0 = 1'b1;
      chk("split_ready", 0, 32'(rdy0), 32'd1);
      @(posedge clk); #1 v0 = 1'b0;   // accepted, now ACC0
      @(posedge clk); #1;             // ACC0 write done, now ACC1
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 0, 32'(rdy0), 32'd0);
      chk("mid_rst_rsp",   0, 32'(rsp0), 32'd0);
      chk("mid_rst_ledr",  0, ledr0, 32'd0);
      chk("mid_rst_hex",   0, 32'(hex0[0]), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_hold_rsp", 0, 32'(rsp0), 32'd0);
      end
      @(negedge clk) rst = 1'b0;
      #1 chk("rel_ready", 0, 32'(rdy0), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("no_late_rsp", i, 32'(rsp0), 32'd0);
      end
      mm[32'h7E] = 8'hD4;
      mm[32'h7F] = 8'hC3;
      for (int i = 0; i < 5; i++) mio[i] = 32'd0;
      do_req(0, 32'h7E, 32'h0, 2'd0, 1'b0, 1'b0, rd, er, lat);
      chk("split_lo_7E", 0, rd, 32'h0000_00D4);
      do_req(0, 32'h7F, 32'h0, 2'd0, 1'b0, 1'b0, rd, er, lat);
      chk("split_lo_7F", 0, rd, 32'h0000_00C3);
      do_req(0, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, rd, er, lat);
      chk("split_hi_80", 0, rd, 32'(b80));
      do_req(0, 32'h81, 32'h0, 2'd0, 1'b0, 1'b0, rd, er, lat);
      chk("split_hi_81", 0, rd, 32'(b81));

      // -------- MISALIGN_EN = 0 instance --------
      do_req(1, 32'h40, 32'h1122_3344, 2'd2, 1'b0, 1'b1, rd, er, lat);
      chk("m0_st_err", 0, 32'(er), 32'd0);
      do_req(1, 32'h41, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat);
      chk("m0_ldw41_err",  0, 32'(er), 32'd1);
      chk("m0_ldw41_data", 0, rd, 32'd0);
      chk("m0_ldw41_lat",  0, 32'(lat), 32'd2);
      do_req(1, 32'h41, 32'hAABB_CCDD, 2'd2, 1'b0, 1'b1, rd, er, lat);
      chk("m0_stw41_err", 0, 32'(er), 32'd1);
      do_req(1, 32'h40, 32'h0, 2'd2, 1'b0, 1'b0, rd, er, lat);
      chk("m0_nowrite", 0, rd, 32'h1122_3344);
      do_req(1, 32'h41, 32'h0, 2'd1, 1'b0, 1'b0, rd, er, lat);
      chk("m0_ldh41_err", 0, 32'(er), 32'd1);
      do_req(1, 32'h42, 32'h0, 2'd1, 1'b0, 1'b0, rd, er, lat);
      chk("m0_ldh42_data", 0, rd, 32'h0000_1122);
      chk("m0_ldh42_err",  0, 32'(er), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mc.md
# lsu_mc

Multi-cycle, parametrised load/store unit for the RV32 core's memory stage. It replaces the single-cycle LSU with a valid/ready request port and a one-cycle response pulse. Internally it owns a byte-enabled synchronous data memory and the memory-mapped IO registers. It splits misaligned accesses that cross a word boundary into two word accesses.

## Interface
Parameters:
- DMEM_WORDS, default 2048: data memory depth in 32-bit words. Must be a power of two.
- NUM_HEX, default 8: number of 7-segment digit outputs, 1..8.
- MISALIGN_EN, default 1: 1 splits crossing accesses; 0 rejects any misaligned access with an error.

Ports:
- i_clk, in, 1: clock.
- i_reset, in, 1: reset. Asynchronous, active-high.
- i_req_valid, in, 1: request present.
- o_req_ready, out, 1: unit can accept a request.
- i_lsu_addr, in, 32: byte address.
- i_st_data, in, 32: store data, right-aligned.
- i_lsu_size, in, 2: access size. 0 = byte, 1 = half, 2 = word, 3 = illegal.
- i_lsu_signed, in, 1: for loads, 1 sign-extends byte/half, 0 zero-extends.
- i_lsu_wren, in, 1: 1 = store, 0 = load.
- o_rsp_valid, out, 1: one-cycle completion pulse, for both loads and stores.
- o_ld_data, out, 32: load result. Valid with o_rsp_valid; 0 for stores and errors.
- o_lsu_err, out, 1: qualified by o_rsp_valid. Set for an illegal size, an unmapped address, a rejected misaligned access, or a crossing access outside DMEM.
- o_io_ledr, out, 32: red LED register.
- o_io_ledg, out, 32: green LED register.
- o_io_hex[0:NUM_HEX-1], out, 7 each: digit i = bits [6:0] of byte i of the HEX registers.
- o_io_lcd, out, 32: LCD register.
- i_io_sw, in, 32: switch inputs, read-only.

## Operation
Address map, decoded on addr[31:12]:
- DMEM: 0x0000_0000 up to DMEM_WORDS*4-1.
- 0x1000_0xxx: LEDR.
- 0x1000_1xxx: LEDG.
- 0x1000_2xxx: HEX0-3.
- 0x1000_3xxx: HEX4-7.
- 0x1000_4xxx: LCD.
- 0x1001_0xxx: SW. Stores to SW are ignored; this is not an error.

Any other address: the store is dropped, the load returns 0, and o_lsu_err is set.

Request acceptance:
- Accept on i_req_valid && o_req_ready at a rising edge; all request fields are captured.
- o_req_ready = (state == IDLE) && !i_reset.

FSM:
- IDLE goes to ACC0 on accept.
- ACC0 issues word 0 (addr[31:2]). It goes to ACC1 if the access crosses, otherwise to RESP.
- ACC1 issues word addr[31:2]+1, then goes to RESP.
- RESP drives o_rsp_valid = 1, then returns to IDLE.
- Errored requests go ACC0 → RESP with no memory or IO side effects.

Misalignment and crossing:
- Misaligned means half with addr[0] = 1, or word with addr[1:0] ≠ 0.
- A crossing access is half with addr[1:0] = 3, or word with addr[1:0] ≠ 0.
- Non-crossing misaligned accesses complete in one word access.
- Crossing accesses to IO are errors.
- With MISALIGN_EN = 0, every misaligned access is an error.

Stores:
- Byte enables and shifted data are derived from addr[1:0] and size.
- Split stores write the low bytes in ACC0 and the remaining high bytes in ACC1.
- IO registers honour byte enables.

Loads:
- Bytes are assembled little-endian from one or two word reads.
- Extension: byte extends from bit 7, half from bit 15. i_lsu_signed is ignored for words.
- The SW value is sampled in ACC0.

## Timing
Latency:
- Request accepted at edge N.
- Aligned or non-crossing access: o_rsp_valid high in the cycle after edge N+2, so throughput is one request per 3 cycles.
- Crossing access: o_rsp_valid one cycle later (after edge N+3).

Stores:
- DMEM and IO registers update at the edge ending ACC0, and at the edge ending ACC1 for the second half.
- A load issued after a store's response sees the new data.

Reset (i_reset asserted):
- Immediately: state = IDLE, o_rsp_valid = 0, o_ld_data = 0, o_lsu_err = 0, o_req_ready = 0.
- LEDR, LEDG, HEX and LCD registers are cleared to 0; all o_io_hex digits read 0.
- DMEM contents are not reset.
- Reset during ACC1 of a split store leaves the first half written and the second half unwritten. This is acceptable.
- The in-flight request is dropped with no response.

Other rules:
- i_req_valid while not ready is ignored. The requester must hold it until accepted.

## Structure
- lsu_pkg holds:
  - size enum: LSU_BYTE, LSU_HALF, LSU_WORD.
  - Region base constants: ADDR_LEDR, ADDR_LEDG, ADDR_HEXLO, ADDR_HEXHI, ADDR_LCD, ADDR_SW.
  - FSM state enum: IDLE, ACC0, ACC1, RESP.
- Sub-module lsu_dmem: a DMEM_WORDS × 32 synchronous-read memory with a 4-bit byte-write-enable.
- The FSM, decode, lane steering and IO registers live in lsu_mc.

## Test plan
- Word store 0x8765_4321 to 0x40, then word load 0x40: response 2 cycles after accept, data 0x8765_4321, err 0.
- Half store 0x0000_F00D to 0x43 (crossing, MISALIGN_EN = 1), then loads:
  - byte 0x43 → 0x0D.
  - byte 0x44 → 0xF0.
  - signed half 0x43 → 0xFFFF_F00D, with response 3 cycles after accept.
  - unsigned half 0x43 → 0x0000_F00D.
- Signed byte load of 0x80 → 0xFFFF_FF80; unsigned → 0x0000_0080.
- IO stores:
  - Word store 0x0000_3F06 to 0x1000_2000: hex[0] = 0x06, hex[1] = 0x3F, other digits 0.
  - Store to 0x1001_0000: ignored.
  - With i_io_sw = 0xDEAD_BEEF, load 0x1001_0000 → 0xDEAD_BEEF.
- Word load at 0x2000_0000: o_lsu_err = 1, data 0. Word load at 0x41 with MISALIGN_EN = 0: o_lsu_err = 1, no write occurs.
- Reset asserted during ACC1 of a split word store at 0x7E: no response, LEDR = 0, ready low during reset then high. Byte 0x7E holds new data; byte 0x80 is unchanged.
